// File: rtl/alu_cmd_ctrl_if.sv
// Command/response handshake bundle between an ALU command source and alu_cmd_ctrl.
// The master issues commands and consumes responses; the slave is the controller.
interface alu_cmd_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_f;
  logic [3:0]       rsp_fr;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_f, rsp_fr
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_f, rsp_fr
  );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Sequences one ALU command through operand load, execute, result wait and response
// phases, driving single-cycle load strobes into the ALU register block.
module alu_cmd_ctrl #(
  parameter int WIDTH = 32,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  alu_cmd_ctrl_if.slave    bus,
  output logic [3:0]       alu_op_o,
  output logic [WIDTH-1:0] data_a_o,
  output logic [WIDTH-1:0] data_b_o,
  output logic             ld_a_o,
  output logic             ld_b_o,
  output logic             ld_f_o,
  input  logic [WIDTH-1:0] alu_f_i,
  input  logic [3:0]       alu_fr_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] op_cnt_o
);

  localparam int WCW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             cmd_ready_q;
  logic             rsp_valid_q;
  logic             busy_q;
  logic             ld_ab_q;
  logic             ld_f_q;
  logic [3:0]       alu_op_q;
  logic [WIDTH-1:0] data_a_q;
  logic [WIDTH-1:0] data_b_q;
  logic [WIDTH-1:0] rsp_f_q;
  logic [3:0]       rsp_fr_q;
  logic [CNT_W-1:0] op_cnt_q;

  logic accept_s;
  logic capture_s;
  logic done_s;

  assign accept_s  = (state_q == S_IDLE) && bus.cmd_valid;
  assign capture_s = (state_q == S_WAIT) && (wcnt_q == WCW'(0));
  assign done_s    = (state_q == S_RESP) && bus.rsp_ready;

  // Next-state and wait-counter decode.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) state_d = S_LOAD;
        else               state_d = S_IDLE;
      end
      S_LOAD: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_WAIT;
        wcnt_d  = WCW'(LAT - 1);
      end
      S_WAIT: begin
        if (wcnt_q == WCW'(0)) state_d = S_RESP;
        else                   wcnt_d  = wcnt_q - WCW'(1);
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
        else               state_d = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, registered strobes and data capture; outputs decode from the next state
  // so every strobe is a flop output aligned with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= WCW'(0);
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ld_ab_q     <= 1'b0;
      ld_f_q      <= 1'b0;
      alu_op_q    <= 4'd0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      rsp_f_q     <= '0;
      rsp_fr_q    <= 4'd0;
      op_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      cmd_ready_q <= (state_d == S_IDLE);
      rsp_valid_q <= (state_d == S_RESP);
      busy_q      <= (state_d != S_IDLE);
      ld_ab_q     <= (state_d == S_LOAD);
      ld_f_q      <= (state_d == S_EXEC);
      if (accept_s) begin
        alu_op_q <= bus.cmd_op;
        data_a_q <= bus.cmd_a;
        data_b_q <= bus.cmd_b;
      end
      if (capture_s) begin
        rsp_f_q  <= alu_f_i;
        rsp_fr_q <= alu_fr_i;
      end
      if (done_s) begin
        op_cnt_q <= op_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_f     = rsp_f_q;
  assign bus.rsp_fr    = rsp_fr_q;
  assign alu_op_o      = alu_op_q;
  assign data_a_o      = data_a_q;
  assign data_b_o      = data_b_q;
  assign ld_a_o        = ld_ab_q;
  assign ld_b_o        = ld_ab_q;
  assign ld_f_o        = ld_f_q;
  assign busy_o        = busy_q;
  assign op_cnt_o      = op_cnt_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl: a LAT=1/CNT_W=16 instance and a LAT=3/CNT_W=2
// instance, each attached to a small behavioural ALU register block.
module tb_alu_cmd_ctrl;
  localparam int W = 32;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  int   n_chk  = 0;
  int   n_pass = 0;

  alu_cmd_ctrl_if #(.WIDTH(W)) if0 ();
  alu_cmd_ctrl_if #(.WIDTH(W)) if1 ();

  logic [3:0]   op0, op1, fr0, fr1;
  logic [W-1:0] da0, db0, da1, db1, f0, f1, ra0, rb0, ra1, rb1;
  logic         la0, lb0, lf0, la1, lb1, lf1, busy0, busy1;
  logic [15:0]  cnt0;
  logic [1:0]   cnt1;

  alu_cmd_ctrl #(.WIDTH(W), .LAT(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst0), .bus(if0.slave), .alu_op_o(op0), .data_a_o(da0), .data_b_o(db0),
    .ld_a_o(la0), .ld_b_o(lb0), .ld_f_o(lf0), .alu_f_i(f0), .alu_fr_i(fr0),
    .busy_o(busy0), .op_cnt_o(cnt0)
  );

  alu_cmd_ctrl #(.WIDTH(W), .LAT(3), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst1), .bus(if1.slave), .alu_op_o(op1), .data_a_o(da1), .data_b_o(db1),
    .ld_a_o(la1), .ld_b_o(lb1), .ld_f_o(lf1), .alu_f_i(f1), .alu_fr_i(fr1),
    .busy_o(busy1), .op_cnt_o(cnt1)
  );

  // Flags {ZF,CF,OF,SF}; CF is carry for ADD and borrow for SUB.
  function automatic logic [35:0] alu_calc(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W:0]   r;
    logic         ovf;
    case (op)
      OP_ADD: begin
        r   = {1'b0, a} + {1'b0, b};
        ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
      end
      OP_SUB: begin
        r   = {1'b0, a} - {1'b0, b};
        ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      end
      default: begin
        r   = {1'b0, a & b};
        ovf = 1'b0;
      end
    endcase
    return {(r[W-1:0] == '0), r[W], ovf, r[W-1], r[W-1:0]};
  endfunction

  // Behavioural register blocks: result is valid from the edge after ld_f onward.
  always_ff @(posedge clk) begin
    if (la0) ra0 <= da0;
    if (lb0) rb0 <= db0;
    if (lf0) {fr0, f0} <= alu_calc(op0, ra0, rb0);
    if (la1) ra1 <= da1;
    if (lb1) rb1 <= db1;
    if (lf1) {fr1, f1} <= alu_calc(op1, ra1, rb1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic r, input logic [3:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (d == 0) begin
      if0.cmd_valid = v; if0.rsp_ready = r; if0.cmd_op = op; if0.cmd_a = a; if0.cmd_b = b;
    end else begin
      if1.cmd_valid = v; if1.rsp_ready = r; if1.cmd_op = op; if1.cmd_a = a; if1.cmd_b = b;
    end
  endtask

  function automatic logic g_rv(input int d);
    return (d == 0) ? if0.rsp_valid : if1.rsp_valid;
  endfunction
  function automatic logic g_rdy(input int d);
    return (d == 0) ? if0.cmd_ready : if1.cmd_ready;
  endfunction
  function automatic logic g_la(input int d);
    return (d == 0) ? (la0 | lb0) : (la1 | lb1);
  endfunction
  function automatic logic g_lf(input int d);
    return (d == 0) ? lf0 : lf1;
  endfunction

  // Issue one command with rsp_ready high; lat is the cycle rsp_valid is first seen
  // counting the accept edge as cycle 0. Returns after the response handshake edge.
  task automatic run_cmd(input int d, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int lat, output int na,
                         output int nf, output int ov);
    int n;
    drive(d, 1'b1, 1'b1, op, a, b);
    n = 0;
    while (!g_rdy(d) && n < 40) begin step(); n++; end
    step();
    drive(d, 1'b0, 1'b1, op, a, b);
    lat = 1; na = 0; nf = 0; ov = 0;
    while (!g_rv(d) && lat < 40) begin
      na += int'(g_la(d));
      nf += int'(g_lf(d));
      ov += int'(g_la(d) & g_lf(d));
      step();
      lat++;
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, na, nf, ov, n;
    logic stable, seen;
    logic [1:0] seq [5];
    seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    rst0 = 1'b1; rst1 = 1'b1;
    drive(0, 1'b0, 1'b1, 4'd0, '0, '0);
    drive(1, 1'b0, 1'b1, 4'd0, '0, '0);
    step(); step();
    rst0 = 1'b0; rst1 = 1'b0;

    check("rst_cmd_ready", 64'(if0.cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(if0.rsp_valid), 64'd0);
    check("rst_busy",      64'(busy0), 64'd0);
    check("rst_op_cnt",    64'(cnt0), 64'd0);
    check("rst_ld",        64'({la0, lb0, lf0}), 64'd0);
    check("rst_data_a",    64'(da0), 64'd0);
    check("rst_u1_ready",  64'(if1.cmd_ready), 64'd1);

    // ADD 5+7 with exact strobe timing
    drive(0, 1'b1, 1'b1, OP_ADD, 32'd5, 32'd7);
    step();
    drive(0, 1'b0, 1'b1, OP_ADD, 32'd5, 32'd7);
    check("t1_c1_ld",    64'({la0, lb0, lf0}), 64'(3'b110));
    check("t1_c1_busy",  64'({busy0, if0.cmd_ready}), 64'(2'b10));
    check("t1_c1_data",  64'({op0, da0, db0[15:0]}), {4'd0, 32'd5, 16'd7, 12'd0} >> 12);
    step();
    check("t1_c2_ld",    64'({la0, lb0, lf0}), 64'(3'b001));
    step();
    check("t1_c3",       64'({la0, lb0, lf0, if0.rsp_valid}), 64'd0);
    step();
    check("t1_c4_valid", 64'(if0.rsp_valid), 64'd1);
    check("t1_c4_f",     64'(if0.rsp_f), 64'd12);
    check("t1_c4_fr",    64'(if0.rsp_fr), 64'(4'b0000));
    step();
    check("t1_cnt",      64'(cnt0), 64'd1);
    check("t1_idle",     64'({if0.rsp_valid, if0.cmd_ready}), 64'(2'b01));

    // SUB cases; rsp_f is read after the handshake to cover retention
    run_cmd(0, OP_SUB, 32'd3, 32'd3, lat, na, nf, ov);
    check("t2_lat",   64'(lat), 64'd4);
    check("t2_pulse", 64'({na[3:0], nf[3:0], ov[3:0]}), 64'(12'h110));
    check("t2_zero_f",  64'(if0.rsp_f), 64'd0);
    check("t2_zero_fr", 64'(if0.rsp_fr), 64'(4'b1000));
    run_cmd(0, OP_SUB, 32'd0, 32'd1, lat, na, nf, ov);
    check("t2_neg_f",   64'(if0.rsp_f), 64'hFFFF_FFFF);
    check("t2_neg_fr",  64'(if0.rsp_fr), 64'(4'b0101));
    check("t2_cnt",     64'(cnt0), 64'd3);

    // Back-pressure with cmd_valid held high
    drive(0, 1'b1, 1'b0, OP_ADD, 32'd10, 32'd20);
    step();
    n = 0;
    while (!if0.rsp_valid && n < 20) begin step(); n++; end
    check("t3_valid", 64'(if0.rsp_valid), 64'd1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!(if0.rsp_valid && if0.rsp_f == 32'd30 && !if0.cmd_ready && !la0 && !lb0 && !lf0))
        stable = 1'b0;
    end
    check("t3_stable", 64'(stable), 64'd1);
    check("t3_f",      64'(if0.rsp_f), 64'd30);
    drive(0, 1'b1, 1'b1, OP_SUB, 32'd9, 32'd4);
    step();
    check("t3_cnt",    64'(cnt0), 64'd4);
    check("t3_ready",  64'({if0.cmd_ready, la0}), 64'(2'b10));
    step();
    drive(0, 1'b0, 1'b1, OP_SUB, 32'd9, 32'd4);
    check("t3_next_ld", 64'({la0, da0}), {31'd0, 1'b1, 32'd9});
    n = 0;
    while (!if0.rsp_valid && n < 20) begin step(); n++; end
    check("t3_next_f", 64'(if0.rsp_f), 64'd5);
    step();
    check("t3_cnt2",   64'(cnt0), 64'd5);

    // Reset during WAIT aborts the command
    drive(0, 1'b1, 1'b1, OP_ADD, 32'd100, 32'd200);
    step(); step(); step();
    drive(0, 1'b0, 1'b1, OP_ADD, 32'd100, 32'd200);
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    check("t4_ready_busy", 64'({if0.cmd_ready, busy0, if0.rsp_valid}), 64'(3'b100));
    check("t4_cnt",        64'(cnt0), 64'd0);
    check("t4_ld",         64'({la0, lb0, lf0}), 64'd0);
    check("t4_regs",       64'({op0, da0[27:0], if0.rsp_fr, if0.rsp_f[27:0]}), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | if0.rsp_valid | la0 | lb0 | lf0;
    end
    check("t4_no_rsp", 64'(seen), 64'd0);

    // LAT=3, CNT_W=2: latency and counter wrap over five back-to-back commands
    for (int i = 0; i < 5; i++) begin
      run_cmd(1, OP_ADD, 32'(i + 1), 32'd1, lat, na, nf, ov);
      if (i == 0) begin
        check("t5_lat",   64'(lat), 64'd6);
        check("t5_pulse", 64'({na[3:0], nf[3:0], ov[3:0]}), 64'(12'h110));
      end
      check($sformatf("t6_f_%0d", i),   64'(if1.rsp_f), 64'(i + 2));
      check($sformatf("t6_cnt_%0d", i), 64'(cnt1), 64'(seq[i]));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
